fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, 72'h0, fetch address loaded on reset.
REQ-002 Parameter INSTR_BYTES, 9, PC increment per instruction (72-bit instruction = 9 bytes).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  output  72  fetch address to InstructionFetch memory; equals pc at all times.
REQ-006 mem_instr  input  72  instruction returned combinationally for mem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_target  input  72  new fetch address; used only when redirect_valid=1.
REQ-009 halt  input  1  stop issuing new fetches.
REQ-010 out_valid  output  1  head of the buffer holds a valid instruction.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_instr  output  72  head-entry instruction.
REQ-013 out_pc  output  72  head-entry fetch address.
REQ-014 pc  output  72  current fetch address.
REQ-015 count  output  2  buffer occupancy, 0..2.
REQ-016 state  output  2  FSM state: 2'b00 FETCH, 2'b01 FULL, 2'b10 HALTED.

Function
REQ-017 The block SHALL contain a 2-entry FIFO of {instruction, pc} pairs; out_valid=(count!=0); out_instr/out_pc SHALL show the head entry.
REQ-018 Pop SHALL occur on a clock edge when out_valid=1 and out_ready=1.
REQ-019 Push SHALL occur on a clock edge in FETCH when (count<2) or pop occurs in the same cycle; the pushed entry is {mem_instr, pc}, and pc SHALL advance by INSTR_BYTES.
REQ-020 Latency: an instruction fetched at edge N SHALL appear on out_instr/out_pc with out_valid=1 immediately after edge N.
REQ-021 Simultaneous push and pop at count=2 or count=1 SHALL leave count unchanged and maintain FIFO order.
REQ-022 pc arithmetic SHALL be modulo 2^72 (wrap to 0 past 72'hFF..FF); no alignment check on any address.
REQ-023 FSM, priority redirect > halt > normal flow:
- any state, redirect_valid=1: flush FIFO (count=0, no push, pop ignored), pc<=redirect_target, next state FETCH.
- FETCH/FULL, halt=1: no push, pc held, pops continue, next state HALTED.
- FETCH: next state FULL when the post-edge count=2 and no pop will be possible without ready; precisely, FULL when post-edge count=2, else FETCH.
- FULL: no push unless pop occurs in the same cycle (then push, stay FULL); next state FETCH when post-edge count<2.
- HALTED: no push, pc held, pops continue; leave only via redirect.
REQ-024 halt deasserting while in HALTED SHALL NOT resume fetching.
REQ-025 mem_addr SHALL equal pc combinationally in every state.

Reset
REQ-026 reset=1 SHALL asynchronously set pc=RESET_PC, count=0, out_valid=0, state=FETCH, FIFO pointers to 0; out_instr/out_pc SHALL be 72'h0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries and pending redirect/halt; first push occurs on the first edge with reset=0.

Verification
REQ-028 Reset release, out_ready=1, mem_instr=f(addr) -> out_pc 0, 9, 18, 27 on consecutive cycles, out_valid=1 from first edge onward, count=1 steady.
REQ-029 out_ready=0 from reset -> count 1 then 2, state FULL, pc=18 held, out_pc=0; out_ready=1 -> pops 0 then 9, fetch resumes at 18, no loss or duplication.
REQ-030 Redirect to 72'h100 with count=2 -> next cycle count=0, out_valid=0, pc=72'h100, state FETCH; following edge out_pc=72'h100.
REQ-031 halt=1 with count=2, out_ready=1 -> state HALTED, two pops, then out_valid=0, pc unchanged; halt=0 keeps HALTED; redirect to 72'h48 -> FETCH, out_pc=72'h48 next.
REQ-032 Redirect to 2^72-9 -> out_pc sequence 72'hFF..F7, then 72'h0, then 72'h9.
REQ-033 Redirect and halt asserted together -> redirect taken, state FETCH; async reset pulse between edges with count=2 -> count=0, pc=RESET_PC immediately without waiting for clk.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: memory fetch port, redirect/halt control and the
// instruction output stream, plus observability of pc, occupancy and state.
interface fetch_controller_if;
    logic [71:0] mem_addr;
    logic [71:0] mem_instr;
    logic        redirect_valid;
    logic [71:0] redirect_target;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_instr;
    logic [71:0] out_pc;
    logic [71:0] pc;
    logic [1:0]  count;
    logic [1:0]  state;

    modport master (
        output mem_addr, out_valid, out_instr, out_pc, pc, count, state,
        input  mem_instr, redirect_valid, redirect_target, halt, out_ready
    );

    modport slave (
        input  mem_addr, out_valid, out_instr, out_pc, pc, count, state,
        output mem_instr, redirect_valid, redirect_target, halt, out_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: fetches 72-bit words at pc into a 2-entry
// FIFO of {instr, pc}, with redirect (flush) taking priority over halt.
//
// state   | meaning
// FETCH   | issuing fetches whenever the FIFO has room (or is popping)
// FULL    | FIFO holds two entries; fetch only alongside a pop
// HALTED  | no fetches, pc frozen, FIFO drains; exits only on redirect
module fetch_controller #(
    parameter logic [71:0] RESET_PC    = 72'h0,
    parameter int          INSTR_BYTES = 9
) (
    input  logic                clk,
    input  logic                reset,
    fetch_controller_if.master  bus
);
    localparam logic [1:0]  ST_FETCH  = 2'b00;
    localparam logic [1:0]  ST_FULL   = 2'b01;
    localparam logic [1:0]  ST_HALTED = 2'b10;
    localparam logic [71:0] PC_STEP   = 72'(INSTR_BYTES);

    logic [71:0] pc_q;
    logic [71:0] fifo_instr [2];
    logic [71:0] fifo_pc    [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        fetching;
    logic        pop;
    logic        push;

    // A redirect discards the FIFO, so a pop in that cycle is ignored.
    always_comb begin
        fetching = (state_q == ST_FETCH) || (state_q == ST_FULL);
        pop      = (count_q != 2'd0) && bus.out_ready && !bus.redirect_valid;
        push     = fetching && !bus.redirect_valid && !bus.halt &&
                   ((count_q != 2'd2) || pop);
    end

    always_comb begin
        count_d = count_q;
        if (bus.redirect_valid) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = ST_FETCH;
        end else if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
        end else if (bus.halt) begin
            state_d = ST_HALTED;
        end else if (count_d == 2'd2) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            state_q       <= ST_FETCH;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_instr[0] <= 72'h0;
            fifo_instr[1] <= 72'h0;
            fifo_pc[0]    <= 72'h0;
            fifo_pc[1]    <= 72'h0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            if (bus.redirect_valid) begin
                pc_q   <= bus.redirect_target;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= bus.mem_instr;
                    fifo_pc[wr_ptr]    <= pc_q;
                    wr_ptr             <= ~wr_ptr;
                    pc_q               <= pc_q + PC_STEP;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    assign bus.mem_addr  = pc_q;
    assign bus.pc        = pc_q;
    assign bus.count     = count_q;
    assign bus.state     = state_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];
endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a queue-based model predicts the
// instruction stream and pc/state; a monitor checks every presented head.
module tb_fetch_controller;
    localparam logic [71:0] RESET_PC = 72'h0;

    typedef struct packed {
        logic [71:0] instr;
        logic [71:0] pc;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    sb_entry_t   q[$];
    logic [71:0] mpc = RESET_PC;
    bit          mhalted = 1'b0;

    fetch_controller_if bus ();

    fetch_controller #(.RESET_PC(RESET_PC), .INSTR_BYTES(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] fmem(input logic [71:0] a);
        return {a[35:0], a[71:36]} ^ 72'hA5_5AA5_C33C_0FF0_9696;
    endfunction

    assign bus.mem_instr = fmem(bus.mem_addr);

    function automatic logic [71:0] exp_state();
        if (mhalted) return 72'd2;
        return (q.size() == 2) ? 72'd1 : 72'd0;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides the coming edge from the
    // architectural rules and commits its update before that edge.
    task automatic cycle(input bit rv, input logic [71:0] tgt, input bit h,
                         input bit rdy, input bit rp);
        sb_entry_t e;
        bit        do_pop;
        bit        do_push;
        e = '0;
        @(negedge clk);
        chk("pc", bus.pc, mpc);
        chk("mem_addr", bus.mem_addr, mpc);
        chk("count", 72'(bus.count), 72'(q.size()));
        chk("state", 72'(bus.state), exp_state());
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.halt            = h;
        bus.out_ready       = rdy;
        if (rp) begin
            reset = 1'b1;
            #1;
            chk("rst_count", 72'(bus.count), 72'd0);
            chk("rst_pc", bus.pc, RESET_PC);
            chk("rst_valid", 72'(bus.out_valid), 72'd0);
            chk("rst_state", 72'(bus.state), 72'd0);
            q.delete();
            mpc     = RESET_PC;
            mhalted = 1'b0;
            reset   = 1'b0;
        end else begin
            #1;
        end
        do_pop  = (q.size() > 0) && rdy && !rv;
        do_push = 1'b0;
        if (rv) begin
            mhalted = 1'b0;
        end else if (h || mhalted) begin
            mhalted = 1'b1;
        end else if (q.size() < 2 || do_pop) begin
            do_push = 1'b1;
            e.instr = fmem(mpc);
            e.pc    = mpc;
        end
        #2;
        if (rv) begin
            q.delete();
            mpc = tgt;
        end else if (do_push) begin
            q.push_back(e);
            mpc = mpc + 72'd9;
        end
    endtask

    // Monitor: compares the presented head against the scoreboard, pops on accept.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("out_valid", 72'(bus.out_valid), 72'(q.size() != 0));
                if (bus.out_valid && q.size() > 0) begin
                    chk("out_pc", bus.out_pc, q[0].pc);
                    chk("out_instr", bus.out_instr, q[0].instr);
                    if (bus.out_ready && !bus.redirect_valid) void'(q.pop_front());
                end
            end
        end
    end

    function automatic logic [71:0] rand72();
        logic [71:0] v;
        v = {8'($urandom), $urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       return v;
            1:       return 72'hFF_FFFF_FFFF_FFFF_FFFF - 72'($urandom_range(0, 40));
            default: return 72'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 72'h0;
        bus.halt            = 1'b0;
        bus.out_ready       = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pc", bus.pc, RESET_PC);
        chk("reset_count", 72'(bus.count), 72'd0);
        chk("reset_valid", 72'(bus.out_valid), 72'd0);
        chk("reset_state", 72'(bus.state), 72'd0);
        chk("reset_out_instr", bus.out_instr, 72'h0);
        chk("reset_out_pc", bus.out_pc, 72'h0);

        // streaming with consumer always ready
        cycle(0, 0, 0, 1, 1);
        repeat (4) cycle(0, 0, 0, 1, 0);
        // back-pressure fills the FIFO, then drain resumes in order
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        // redirect while full
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 72'h100, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);
        // halt while full, drain, halt release stays halted, redirect resumes
        repeat (2) cycle(0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 1, 0);
        repeat (2) cycle(0, 0, 0, 1, 0);
        cycle(1, 72'h48, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);
        // pc wrap at the top of the address space
        cycle(1, 72'hFF_FFFF_FFFF_FFFF_FFF7, 0, 1, 0);
        repeat (4) cycle(0, 0, 0, 1, 0);
        // redirect and halt together: redirect wins
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 72'h200, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        // async reset pulse with a full FIFO
        cycle(0, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            bit rv, h, rdy, rp;
            rv  = ($urandom_range(0, 99) < 4);
            h   = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < 65);
            rp  = ($urandom_range(0, 199) == 0) && !rv && !h;
            cycle(rv, rand72(), h, rdy, rp);
        end
        repeat (3) cycle(0, 0, 0, 1, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
